// File: rtl/riscv_defines.sv
// Shared RISC-V definitions for the iterative multiply/divide unit:
// M-extension operation encodings and the MDU control states.
package riscv_defines;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iterative_if.sv
// Request/result bundle of the iterative MDU.
// Both handshakes transfer on a rising edge where valid && ready are both high; flush overrides both.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            start_valid;
  logic            start_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start_valid, funct3, op_a, op_b, flush, result_ready,
    input  start_ready, result_valid, result, busy
  );

  modport slave (
    input  start_valid, funct3, op_a, op_b, flush, result_ready,
    output start_ready, result_valid, result, busy
  );
endinterface

// File: rtl/mdu_decoder.sv
// Combinational funct3 decode: operation, divide select and operand signedness.
// want_high selects the upper accumulator half: MULH* product high word, or REM* remainder.
module mdu_decoder
  import riscv_defines::*;
(
  input  logic [2:0] funct3,
  output mdu_op_t    op,
  output logic       is_div,
  output logic       a_signed,
  output logic       b_signed,
  output logic       want_high
);

  always_comb begin
    op        = mdu_op_t'(funct3);
    is_div    = funct3[2];
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    want_high = 1'b0;
    unique case (mdu_op_t'(funct3))
      MDU_MUL:    begin a_signed = 1'b1; b_signed = 1'b1; end
      MDU_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; want_high = 1'b1; end
      MDU_MULHSU: begin a_signed = 1'b1; want_high = 1'b1; end
      MDU_MULHU:  want_high = 1'b1;
      MDU_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
      MDU_DIVU:   ;
      MDU_REM:    begin a_signed = 1'b1; b_signed = 1'b1; want_high = 1'b1; end
      MDU_REMU:   want_high = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, sharing one 2*XLEN accumulator and one XLEN+1-bit adder.
module mdu_iterative
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mdu_iterative_if.slave bus,
  output mdu_state_t    state_dbg
);

  localparam int CW = $clog2(XLEN);

  mdu_state_t        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   divisor;
  logic              is_div_q, want_high_q, neg_main_q, neg_rem_q, bypass_q;

  mdu_op_t dec_op;
  logic    dec_is_div, dec_a_signed, dec_b_signed, dec_want_high;

  mdu_decoder u_dec (
    .funct3    (bus.funct3),
    .op        (dec_op),
    .is_div    (dec_is_div),
    .a_signed  (dec_a_signed),
    .b_signed  (dec_b_signed),
    .want_high (dec_want_high)
  );

  // Request-side decode, only meaningful while IDLE.
  logic            a_neg, b_neg, div_zero, div_ovf, bypass, accept;
  logic [XLEN-1:0] a_mag, b_mag, bypass_val;

  always_comb begin
    a_neg    = dec_a_signed & bus.op_a[XLEN-1];
    b_neg    = dec_b_signed & bus.op_b[XLEN-1];
    a_mag    = a_neg ? -bus.op_a : bus.op_a;
    b_mag    = b_neg ? -bus.op_b : bus.op_b;
    div_zero = dec_is_div && (bus.op_b == '0);
    div_ovf  = ((dec_op == MDU_DIV) || (dec_op == MDU_REM)) &&
               (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);
    bypass   = div_zero || div_ovf;
    if (div_zero) bypass_val = dec_want_high ? bus.op_a : '1;
    else          bypass_val = dec_want_high ? '0 : bus.op_a;
    accept   = bus.start_valid && (state == IDLE) && !bus.flush;
  end

  // Shared adder: multiply adds the multiplicand into the high half when the
  // low bit is set; divide subtracts the divisor from the shifted remainder.
  logic [XLEN:0]     add_a, add_b, sum;
  logic              q_bit;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    add_a = is_div_q ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
    if (is_div_q)    add_b = ~{1'b0, divisor};
    else if (acc[0]) add_b = {1'b0, divisor};
    else             add_b = '0;
    sum   = add_a + add_b + {{XLEN{1'b0}}, is_div_q};
    q_bit = ~sum[XLEN];
    if (is_div_q)
      acc_nxt = {(q_bit ? sum[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], q_bit};
    else
      acc_nxt = {sum, acc[XLEN-1:1]};
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start_valid) state_nxt = bypass ? DONE : CALC;
        CALC:    if (cnt == CW'(XLEN-1)) state_nxt = DONE;
        DONE:    if (bus.result_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      divisor     <= '0;
      is_div_q    <= 1'b0;
      want_high_q <= 1'b0;
      neg_main_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      bypass_q    <= 1'b0;
    end else if (accept) begin
      cnt         <= '0;
      divisor     <= b_mag;
      is_div_q    <= dec_is_div;
      want_high_q <= dec_want_high;
      neg_main_q  <= a_neg ^ b_neg;
      neg_rem_q   <= a_neg;
      bypass_q    <= bypass;
      acc         <= {{XLEN{1'b0}}, (bypass ? bypass_val : a_mag)};
    end else if ((state == CALC) && !bus.flush) begin
      cnt <= cnt + CW'(1);
      acc <= acc_nxt;
    end
  end

  // Sign fix-up is applied combinationally in DONE; acc is frozen there.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res;

  always_comb begin
    prod = neg_main_q ? -acc : acc;
    quo  = neg_main_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (bypass_q)      res = acc[XLEN-1:0];
    else if (is_div_q) res = want_high_q ? rem : quo;
    else               res = want_high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign bus.start_ready  = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = (state == DONE) ? res : '0;
  assign state_dbg        = state;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative at XLEN=32: vector table of ops with expected
// results and latencies, plus backpressure, flush and mid-operation reset sequences.
module tb_mdu_iterative;
  import riscv_defines::*;

  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  mdu_state_t state_dbg;

  mdu_iterative_if #(.XLEN(W)) bus ();

  mdu_iterative #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drivers
  task automatic drive_idle();
    bus.start_valid  = 1'b0;
    bus.funct3       = 3'b000;
    bus.op_a         = '0;
    bus.op_b         = '0;
    bus.flush        = 1'b0;
    bus.result_ready = 1'b1;
  endtask

  // Presents a request at a negedge; returns after the accept edge, at the next negedge.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.funct3      = f;
    bus.op_a        = a;
    bus.op_b        = b;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until result_valid; first sample is cycle 1.
  task automatic wait_result(output int lat, output bit ok);
    lat = 1;
    ok  = 1'b1;
    while (!bus.result_valid) begin
      if (lat >= 100) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int           lat;
    bit           ok;
    logic [W-1:0] e;
    exp_q.push_back(v.exp);
    issue(v.f, v.a, v.b);
    wait_result(lat, ok);
    e = exp_q.pop_front();
    if (!ok) begin
      check($sformatf("vec%0d_timeout", idx), 32'(bus.result_valid), 32'd1);
      return;
    end
    check($sformatf("vec%0d_result", idx), bus.result, e);
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.lat));
    @(negedge clk);
    check($sformatf("vec%0d_back_to_idle", idx), 32'(bus.start_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, 32'(bus.start_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, "_result"}, bus.result, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic expect_no_result(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.result_valid) seen++;
    end
    check({tag, "_no_result"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat;
    bit ok;

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // funct3, op_a, op_b, expected, cycles from accept to result_valid
    add_vec(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    add_vec(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    add_vec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    add_vec(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    add_vec(3'b000, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFB, 33);
    add_vec(3'b001, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 33);
    add_vec(3'b011, 32'h80000000, 32'd4,        32'h00000002, 33);
    add_vec(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    add_vec(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    add_vec(3'b101, 32'd100,      32'd7,        32'd14,       33);
    add_vec(3'b111, 32'd100,      32'd7,        32'd2,        33);
    add_vec(3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
    add_vec(3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);
    add_vec(3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    add_vec(3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        33);
    add_vec(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
    add_vec(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    add_vec(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add_vec(3'b111, 32'd5,        32'd0,        32'd5,        1);
    add_vec(3'b101, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1);
    add_vec(3'b110, 32'd7,        32'd0,        32'd7,        1);
    add_vec(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add_vec(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: result held for three cycles, new requests ignored meanwhile.
    bus.result_ready = 1'b0;
    issue(3'b000, 32'd7, 32'd5);
    wait_result(lat, ok);
    check("bp_valid_reached", 32'(ok), 32'd1);
    bus.start_valid = 1'b1;
    bus.funct3      = 3'b101;
    bus.op_a        = 32'd1;
    bus.op_b        = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", i), 32'(bus.result_valid), 32'd1);
      check($sformatf("bp_hold%0d_result", i), bus.result, 32'd35);
      check($sformatf("bp_hold%0d_start_ready", i), 32'(bus.start_ready), 32'd0);
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", 32'(state_dbg), 32'(IDLE));
    check("bp_release_valid", 32'(bus.result_valid), 32'd0);
    check("bp_release_result_zero", bus.result, 32'd0);

    // Flush ten cycles into CALC.
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("flush_in_calc", 32'(state_dbg), 32'(CALC));
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_idle", 32'(state_dbg), 32'(IDLE));
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_valid", 32'(bus.result_valid), 32'd0);
    expect_no_result("flush", 40);

    // Flush in DONE drops a pending result.
    bus.result_ready = 1'b0;
    issue(3'b100, 32'd5, 32'd0);
    check("flush_done_valid", 32'(bus.result_valid), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush        = 1'b0;
    bus.result_ready = 1'b1;
    check("flush_done_idle", 32'(state_dbg), 32'(IDLE));
    check("flush_done_dropped", 32'(bus.result_valid), 32'd0);

    // Reset mid-CALC.
    issue(3'b000, 32'd3, 32'd9);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_result("rst_mid", 40);

    // Unit is usable again after the aborted operations.
    vecs.delete();
    add_vec(3'b000, 32'd3, 32'd9, 32'd27, 33);
    run_vec(100, vecs[0]);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
MDU_ITERATIVE -- requirements
Module: mdu_iterative

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_valid  input  1  operation request.
REQ-005 SHALL have port start_ready  output  1  unit can accept a request.
REQ-006 SHALL have port funct3  input  3  RV M-extension op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports op_a, op_b  input  XLEN  rs1 and rs2 values.
REQ-008 SHALL have port flush  input  1  abort the in-flight operation.
REQ-009 SHALL have port result_valid  output  1  result available.
REQ-010 SHALL have port result_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; start_ready = (state == IDLE).
REQ-014 Accept on start_valid && start_ready; SHALL latch funct3, op_a, op_b; ignore inputs while not in IDLE.
REQ-015 IDLE->CALC on accept; CALC runs exactly XLEN iterations (counter 0..XLEN-1), then ->DONE; first result_valid is XLEN+1 cycles after the accept edge.
REQ-016 Multiply SHALL be radix-2 shift-add on operand magnitudes into a 2*XLEN product, negated at the end when signs differ; MUL returns low XLEN bits, MULH/MULHSU/MULHU return high XLEN bits with op_a/op_b signedness (s,s)/(s,u)/(u,u).
REQ-017 Divide SHALL be radix-2 restoring on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a) for DIV/REM; unsigned for DIVU/REMU.
REQ-018 Divisor zero SHALL bypass CALC (IDLE->DONE, result_valid next cycle): DIV/DIVU -> all ones; REM/REMU -> op_a.
REQ-019 Signed overflow (op_a = most-negative, op_b = all ones, DIV/REM) SHALL bypass CALC: DIV -> op_a, REM -> 0.
REQ-020 DONE: result_valid high, result stable until result_valid && result_ready; then ->IDLE on that edge (no same-cycle new accept).
REQ-021 flush SHALL force ->IDLE from any state on the next edge, dropping the result; result_valid low the following cycle; flush has priority over accept and result handshake.
REQ-022 result SHALL read 0 whenever result_valid is low.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, counter 0, operand/accumulator registers 0; outputs: start_ready 1, busy 0, result_valid 0, result 0.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no result is produced after release.

Structure
REQ-025 Shared package riscv_defines SHALL hold mdu_op_t (MDU_MUL..MDU_REMU, encoded as funct3) and mdu_state_t (IDLE, CALC, DONE).
REQ-026 A combinational sub-module mdu_decoder SHALL map funct3 to mdu_op_t plus flags is_div, a_signed, b_signed, want_high.
REQ-027 Datapath SHALL use one shared 2*XLEN accumulator and one XLEN+1-bit adder/subtractor for both mul and div.

Verification (XLEN=32)
REQ-028 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, result_valid exactly 33 cycles after accept.
REQ-029 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-031 DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 result_ready low 3 cycles in DONE -> result_valid and result held, start_ready low; on release -> IDLE next cycle.
REQ-033 flush at cycle 10 of CALC -> IDLE next edge, no result_valid; rst_n low mid-CALC -> all outputs at reset values immediately, no result after release.
